// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer in front of a word-wide data memory (RV32I load/store).
// Latency: grant in IDLE (cycle N); response at N+1 (reject), N+2 (load, SW), N+3 (SB/SH).
// Backpressure: one access in flight; requesters hold req until gnt, losers retry in the next IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   pN_req/we/funct3/addr/wdata  -> request from the LSU (N=0) and debug/DMA (N=1)
//   pN_gnt, pN_rvalid, pN_rdata, pN_err <- acceptance pulse and completion
//   mem_read/write/addr/wdata, mem_rdata <-> word memory (combinational read)
// Optional: DMEM_ACCESS_CTRL_STATS_EN adds saturating counters stat_p0_cnt,
//   stat_p1_cnt and stat_err_cnt.
module dmem_access_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef DMEM_ACCESS_CTRL_STATS_EN
  output logic [15:0]       stat_p0_cnt,
  output logic [15:0]       stat_p1_cnt,
  output logic [15:0]       stat_err_cnt,
`endif
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [2:0]        p0_funct3,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [2:0]        p1_funct3,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;     // port granted most recently
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         word_q, word_d;     // memory word captured at the end of RD

  // Arbitration: a lone requester wins; on contention the port not served last wins.
  logic                any_req, sel;
  logic                sel_we;
  logic [2:0]          sel_f3;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic                gnt;

  assign any_req   = p0_req | p1_req;
  assign sel       = (p0_req & p1_req) ? ~last_q : p1_req;
  assign sel_we    = sel ? p1_we     : p0_we;
  assign sel_f3    = sel ? p1_funct3 : p0_funct3;
  assign sel_addr  = sel ? p1_addr   : p0_addr;
  assign sel_wdata = sel ? p1_wdata  : p0_wdata;
  assign gnt       = reset & (state_q == IDLE) & any_req;
  assign p0_gnt    = gnt & ~sel;
  assign p1_gnt    = gnt & sel;

  // Acceptance checks on the selected request.
  logic [1:0]        size_m1;
  logic [ADDR_W:0]   last_byte;   // one bit wider so addr+size-1 cannot wrap
  logic              misal, oor, illegal;

  always_comb begin
    size_m1 = 2'd3;
    case (sel_f3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

  assign last_byte = {1'b0, sel_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
  assign oor       = last_byte >= (ADDR_W+1)'(MEM_BYTES);
  assign misal     = ((sel_f3[1:0] == 2'b01) & sel_addr[0]) |
                     ((sel_f3[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00));
  assign illegal   = sel_we ? !(sel_f3 inside {3'b000, 3'b001, 3'b010})
                            : !(sel_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          last_d  = sel;
          port_d  = sel;
          we_d    = sel_we;
          f3_d    = sel_f3;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = misal | oor | illegal;
          if (misal | oor | illegal)             state_d = RESP;
          else if (sel_we && sel_f3[1:0] == 2'b10) state_d = WR;   // SW needs no merge read
          else                                     state_d = RD;
        end
      end
      RD: begin
        word_d  = mem_rdata;
        state_d = we_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;     // so p0 wins the first contention
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

  // Store merge: only the addressed lane is replaced in the word read during RD.
  logic [31:0] merged;
  always_comb begin
    merged = word_q;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Load lane extraction; funct3[2] selects zero extension.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  assign ld_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = word_q[{addr_q[1], 4'b0000} +: 16];
  always_comb begin
    ld_val = word_q;
    case (f3_q[1:0])
      2'b00:   ld_val = f3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = f3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = word_q;
    endcase
  end

  logic        in_resp;
  logic [31:0] resp_data;
  assign in_resp   = (state_q == RESP);
  assign resp_data = (in_resp && !we_q && !err_q) ? ld_val : 32'h0;

  assign p0_rvalid = in_resp & ~port_q;
  assign p1_rvalid = in_resp & port_q;
  assign p0_rdata  = port_q ? 32'h0 : resp_data;
  assign p1_rdata  = port_q ? resp_data : 32'h0;
  assign p0_err    = p0_rvalid & err_q;
  assign p1_err    = p1_rvalid & err_q;

  assign mem_read  = (state_q == RD);
  assign mem_write = (state_q == WR);
  assign mem_addr  = (mem_read | mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_write ? merged : 32'h0;

`ifdef DMEM_ACCESS_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_p0_cnt  <= 16'h0;
      stat_p1_cnt  <= 16'h0;
      stat_err_cnt <= 16'h0;
    end else if (in_resp) begin
      if (!port_q && stat_p0_cnt != 16'hFFFF)  stat_p0_cnt  <= stat_p0_cnt + 16'h1;
      if (port_q && stat_p1_cnt != 16'hFFFF)   stat_p1_cnt  <= stat_p1_cnt + 16'h1;
      if (err_q && stat_err_cnt != 16'hFFFF)   stat_err_cnt <= stat_err_cnt + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected responses,
// monitors on the falling edge pop and compare rvalid data/err/latency and memory writes.
// Bench waits are bounded; the summary line is always reached.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [2:0]  f3    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ACCESS_CTRL_STATS_EN
  logic [15:0] stat_p0_cnt, stat_p1_cnt, stat_err_cnt;
  int          n_done0, n_done1, n_err;
`endif

  dmem_access_ctrl #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
`ifdef DMEM_ACCESS_CTRL_STATS_EN
    .stat_p0_cnt(stat_p0_cnt), .stat_p1_cnt(stat_p1_cnt), .stat_err_cnt(stat_err_cnt),
`endif
    .p0_req(req[0]), .p0_we(we[0]), .p0_funct3(f3[0]), .p0_addr(addr[0]), .p0_wdata(wd[0]),
    .p0_gnt(gnt[0]), .p0_rvalid(rvalid[0]), .p0_rdata(rdata0), .p0_err(err[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_funct3(f3[1]), .p1_addr(addr[1]), .p1_wdata(wd[1]),
    .p1_gnt(gnt[1]), .p1_rvalid(rvalid[1]), .p1_rdata(rdata1), .p1_err(err[1]),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte memory model with combinational word read.
  logic [7:0] mem [0:1023];
  logic [9:0] wa;
  assign wa = {mem_addr[9:2], 2'b00};
  assign mem_rdata = {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
  always @(posedge clk) begin
    if (mem_write) begin
      mem[wa]         <= mem_wdata[7:0];
      mem[wa + 10'd1] <= mem_wdata[15:8];
      mem[wa + 10'd2] <= mem_wdata[23:16];
      mem[wa + 10'd3] <= mem_wdata[31:24];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int due; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; int due; } wexp_t;
  exp_t  q0[$], q1[$];
  wexp_t wq[$];
  int    gord[$];
  int    checks = 0, fails = 0, rd_cnt = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic unexpected(string name);
    checks++;
    fails++;
    $display("FAIL %s: got unexpected pulse expected none (cycle %0d)", name, cyc);
  endtask

  // Response and memory-write monitors.
  always @(negedge clk) begin
    exp_t  e;
    wexp_t w;
    if (rvalid[0]) begin
      if (q0.size() == 0) unexpected("p0_rvalid");
      else begin
        e = q0.pop_front();
        chk("p0_rdata", rdata0, e.rdata);
        chk("p0_err", 32'(err[0]), 32'(e.err));
        chk("p0_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (rvalid[1]) begin
      if (q1.size() == 0) unexpected("p1_rvalid");
      else begin
        e = q1.pop_front();
        chk("p1_rdata", rdata1, e.rdata);
        chk("p1_err", 32'(err[1]), 32'(e.err));
        chk("p1_latency", 32'(cyc), 32'(e.due));
      end
    end
    if (mem_write) begin
      if (wq.size() == 0) unexpected("mem_write");
      else begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", mem_wdata, w.d);
        chk("wr_cycle", 32'(cyc), 32'(w.due));
      end
    end
    if (mem_read || mem_write) chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
    if (mem_read) rd_cnt++;
  end

  // Issue one request on port p and register the expected outcome at grant time.
  task automatic do_req(int p, bit w, bit [2:0] fn, bit [31:0] a, bit [31:0] d,
                        bit [31:0] exp_rd, bit exp_err, bit [31:0] exp_wd);
    int   lat;
    bit   got;
    exp_t e;
    wexp_t x;
    lat = exp_err ? 1 : (!w ? 2 : (fn == 3'b010 ? 2 : 3));
    we[p] = w; f3[p] = fn; addr[p] = a; wd[p] = d; req[p] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt[p]) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL p%0d_grant_timeout: got no grant expected grant within 50 cycles", p);
      req[p] = 1'b0;
      return;
    end
    gord.push_back(p);
    e.rdata = exp_rd; e.err = exp_err; e.due = cyc + lat;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    if (w && !exp_err) begin
      x.a = {a[31:2], 2'b00}; x.d = exp_wd; x.due = cyc + lat - 1;
      wq.push_back(x);
    end
`ifdef DMEM_ACCESS_CTRL_STATS_EN
    if (p == 0) n_done0++; else n_done1++;
    if (exp_err) n_err++;
`endif
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && wq.size() == 0) begin done = 1'b1; break; end
      @(posedge clk);
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size() + wq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_gnt_rvalid_err"}, {26'h0, gnt, rvalid, err}, 32'h0);
    chk({tag, "_rdata0"}, rdata0, 32'h0);
    chk({tag, "_rdata1"}, rdata1, 32'h0);
    chk({tag, "_mem_rw"}, {30'h0, mem_read, mem_write}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  int snap;
  bit got_g;

  initial begin
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; f3[p] = 3'b0; addr[p] = 32'h0; wd[p] = 32'h0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = 8'h0;
    {mem[3], mem[2], mem[1], mem[0]}     = 32'h10080402;
    {mem[7], mem[6], mem[5], mem[4]}     = 32'h0313070C;
    {mem[11], mem[10], mem[9], mem[8]}   = 32'h44332211;
    {mem[23], mem[22], mem[21], mem[20]} = 32'hD4C3B2A1;
`ifdef DMEM_ACCESS_CTRL_STATS_EN
    n_done0 = 0; n_done1 = 0; n_err = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Contention from reset: p0 first, then strict alternation.
    fork
      begin
        for (int k = 0; k < 3; k++) do_req(0, 0, 3'b010, 32'd0, 32'h0, 32'h10080402, 0, 32'h0);
      end
      begin
        for (int k = 0; k < 3; k++) do_req(1, 0, 3'b010, 32'd0, 32'h0, 32'h10080402, 0, 32'h0);
      end
    join
    wait_idle();
    chk("arb_grant_count", 32'(gord.size()), 32'd6);
    for (int i = 0; i < gord.size(); i++) chk("arb_order", 32'(gord[i]), 32'(i % 2));

    // Loads and sub-word stores on p0.
    do_req(0, 0, 3'b100, 32'd1, 32'h0, 32'h00000004, 0, 32'h0);            // LBU 1
    do_req(0, 1, 3'b000, 32'd5, 32'h000000F0, 32'h0, 0, 32'h0313F00C);     // SB 5
    do_req(0, 0, 3'b000, 32'd5, 32'h0, 32'hFFFFFFF0, 0, 32'h0);            // LB 5
    do_req(0, 0, 3'b101, 32'd4, 32'h0, 32'h0000F00C, 0, 32'h0);            // LHU 4
    do_req(0, 0, 3'b001, 32'd6, 32'h0, 32'h00000313, 0, 32'h0);            // LH 6
    do_req(0, 1, 3'b001, 32'd10, 32'h00008001, 32'h0, 0, 32'h80012211);    // SH 10
    do_req(0, 0, 3'b001, 32'd10, 32'h0, 32'hFFFF8001, 0, 32'h0);           // LH 10
    do_req(0, 1, 3'b010, 32'd12, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF);    // SW 12
    do_req(0, 0, 3'b001, 32'd14, 32'h0, 32'hFFFFDEAD, 0, 32'h0);           // LH 14
    do_req(0, 0, 3'b000, 32'd12, 32'h0, 32'hFFFFFFEF, 0, 32'h0);           // LB 12
    wait_idle();

    // Rejections on p1 must not touch memory.
    snap = rd_cnt;
    do_req(1, 0, 3'b010, 32'd2, 32'h0, 32'h0, 1, 32'h0);                   // LW misaligned
    do_req(1, 1, 3'b001, 32'd3, 32'h0000BEEF, 32'h0, 1, 32'h0);            // SH misaligned
    do_req(1, 0, 3'b010, 32'd1024, 32'h0, 32'h0, 1, 32'h0);                // LW out of range
    do_req(1, 0, 3'b011, 32'd0, 32'h0, 32'h0, 1, 32'h0);                   // illegal load
    do_req(1, 1, 3'b100, 32'd0, 32'hFFFFFFFF, 32'h0, 1, 32'h0);            // illegal store
    do_req(1, 0, 3'b010, 32'd1021, 32'h0, 32'h0, 1, 32'h0);                // LW misaligned near top
    wait_idle();
    chk("err_no_mem_read", 32'(rd_cnt), 32'(snap));
    do_req(1, 0, 3'b100, 32'd1023, 32'h0, 32'h0, 0, 32'h0);                // LBU last byte
    do_req(1, 0, 3'b001, 32'd1022, 32'h0, 32'h0, 0, 32'h0);                // LH last half
    do_req(1, 0, 3'b010, 32'd1020, 32'h0, 32'h0, 0, 32'h0);                // LW last word
    do_req(1, 0, 3'b010, 32'd0, 32'h0, 32'h10080402, 0, 32'h0);            // memory unchanged
    wait_idle();

    // Reset during the WR cycle of an SB.
    we[0] = 1'b1; f3[0] = 3'b000; addr[0] = 32'd21; wd[0] = 32'h00000055; req[0] = 1'b1;
    got_g = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[0]) begin got_g = 1'b1; break; end
    end
    chk("rst_sb_granted", 32'(got_g), 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_sb_in_wr", 32'(mem_write), 32'h1);
    chk("rst_sb_wr_addr", mem_addr, 32'd20);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
`ifdef DMEM_ACCESS_CTRL_STATS_EN
    n_done0 = 0; n_done1 = 0; n_err = 0;
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("rst_byte_unchanged", 32'(mem[21]), 32'h000000B2);
    gord.delete();
    fork
      do_req(0, 0, 3'b010, 32'd20, 32'h0, 32'hD4C3B2A1, 0, 32'h0);
      do_req(1, 0, 3'b010, 32'd20, 32'h0, 32'hD4C3B2A1, 0, 32'h0);
    join
    wait_idle();
    chk("post_rst_first_grant", 32'(gord[0]), 32'd0);

`ifdef DMEM_ACCESS_CTRL_STATS_EN
    do_req(0, 0, 3'b010, 32'd0, 32'h0, 32'h10080402, 0, 32'h0);
    do_req(0, 0, 3'b010, 32'd0, 32'h0, 32'h10080402, 0, 32'h0);
    do_req(1, 0, 3'b010, 32'd2, 32'h0, 32'h0, 1, 32'h0);
    wait_idle();
    chk("stat_p0", 32'(stat_p0_cnt), 32'(n_done0));
    chk("stat_p1", 32'(stat_p1_cnt), 32'(n_done1));
    chk("stat_err", 32'(stat_err_cnt), 32'(n_err));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
